// File: rtl/key_note_recorder_pkg.sv
// Shared types and constants for the key note recorder.
package key_note_recorder_pkg;

  // State encoding matches the externally visible state port.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRecord = 2'd1,
    StPlay   = 2'd2
  } rec_state_e;

  localparam logic [3:0] REST_NOTE = 4'd15;
  localparam logic [3:0] MAX_NOTE  = 4'd13;

  function automatic logic note_is_valid(input logic [3:0] note);
    return note <= MAX_NOTE;
  endfunction

endpackage

// File: rtl/key_note_recorder_note_fifo.sv
// note_fifo: note storage with a write port, indexed read and a registered
// count with full/empty flags. Storage itself is not reset.
module note_fifo #(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          wr_en,
  input  logic [3:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [3:0]    rd_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, empty_q;
  logic          do_write;

  // Next write pointer and count; clear wins over a write, writes drop when full.
  always_comb begin
    do_write = wr_en && !clear && (count_q < CW'(DEPTH));
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (do_write) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      count_d  = count_q + CW'(1);
    end
  end

  // Pointer, count and flags, flags derived from the next count so they stay aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CW'(DEPTH));
      empty_q  <= (count_d == '0);
    end
  end

  // Note storage write.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];
  assign count   = count_q;
  assign full    = full_q;
  assign empty   = empty_q;

endmodule

// File: rtl/key_note_recorder.sv
// key_note_recorder: records keyboard notes and plays them back, one beat each.
// Optional macro LOOP_PLAY_EN: playback wraps to the first note instead of
// returning to idle after one pass.
module key_note_recorder
  import key_note_recorder_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned BEAT_CYCLES = 25_000_000,
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    note_in,
  input  logic          note_valid,
  input  logic          rec_start,
  input  logic          play_start,
  input  logic          stop,
  output logic [3:0]    note_out,
  output logic [1:0]    state,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned BW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;

  rec_state_e    state_q, state_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [3:0]    note_q, note_d;
  logic [3:0]    rd_data;
  logic          fifo_clear, fifo_wr;
  logic          beat_done, last_entry;

  note_fifo #(
    .DEPTH (DEPTH)
  ) u_note_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear   (fifo_clear),
    .wr_en   (fifo_wr),
    .wr_data (note_in),
    .rd_addr (rd_ptr_d),
    .rd_data (rd_data),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // Next-state, pointer/beat updates and the registered note output value.
  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    beat_d     = beat_q;
    fifo_clear = 1'b0;
    fifo_wr    = 1'b0;
    beat_done  = (beat_q == BW'(BEAT_CYCLES - 1));
    last_entry = ((CW'(rd_ptr_q) + CW'(1)) == count);

    if (stop) begin
      state_d = StIdle;
    end else if (rec_start) begin
      state_d    = StRecord;
      fifo_clear = 1'b1;
    end else begin
      case (state_q)
        StIdle, StRecord: begin
          if (state_q == StRecord && note_valid && note_is_valid(note_in)) begin
            fifo_wr = 1'b1;
          end
          if (play_start && !empty) begin
            state_d  = StPlay;
            rd_ptr_d = '0;
            beat_d   = '0;
          end
        end
        StPlay: begin
          if (beat_done) begin
            beat_d = '0;
            if (last_entry) begin
`ifdef LOOP_PLAY_EN
              rd_ptr_d = '0;
`else
              state_d = StIdle;
`endif
            end else begin
              rd_ptr_d = rd_ptr_q + AW'(1);
            end
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // The read address follows the next pointer so note_out lines up with it.
    note_d = (state_d == StPlay) ? rd_data : REST_NOTE;
  end

  // State, read pointer, beat counter and output note registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      rd_ptr_q <= '0;
      beat_q   <= '0;
      note_q   <= REST_NOTE;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      beat_q   <= beat_d;
      note_q   <= note_d;
    end
  end

  assign note_out = note_q;
  assign state    = state_q;

endmodule

// File: tb/tb_key_note_recorder.sv
// Scoreboard bench for key_note_recorder (DEPTH = 4, BEAT_CYCLES = 4).
module tb_key_note_recorder;

  typedef struct packed {
    logic [3:0] note;
    logic [1:0] st;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] note_in = 4'd0;
  logic       note_valid = 1'b0;
  logic       rec_start = 1'b0;
  logic       play_start = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] note_out;
  logic [1:0] state;
  logic [2:0] count;
  logic       full;
  logic       empty;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  key_note_recorder #(
    .DEPTH       (4),
    .BEAT_CYCLES (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .note_in    (note_in),
    .note_valid (note_valid),
    .rec_start  (rec_start),
    .play_start (play_start),
    .stop       (stop),
    .note_out   (note_out),
    .state      (state),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  // Monitor: while expectations are queued, compare one per cycle on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (note_out !== e.note || state !== e.st) begin
          failures++;
          $display("FAIL play_seq: got note=%0d state=%0d expected note=%0d state=%0d",
                   note_out, state, e.note, e.st);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_rec();
    rec_start = 1'b1;
    tick();
    rec_start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic do_play();
    play_start = 1'b1;
    tick();
    play_start = 1'b0;
  endtask

  task automatic do_note(input logic [3:0] n);
    note_in    = n;
    note_valid = 1'b1;
    tick();
    note_valid = 1'b0;
  endtask

  // Start playback and queue the per-cycle expected note/state stream.
  task automatic run_play(input int n, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] d);
    logic [3:0] v[4];
    int passes;
    int waited;
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
`ifdef LOOP_PLAY_EN
    passes = 2;
`else
    passes = 1;
`endif
    do_play();
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < n; i++)
        for (int k = 0; k < 4; k++) exp_q.push_back('{note: v[i], st: 2'd2});
`ifndef LOOP_PLAY_EN
    exp_q.push_back('{note: 4'd15, st: 2'd0});
    exp_q.push_back('{note: 4'd15, st: 2'd0});
`endif
    waited = 0;
    while (exp_q.size() > 0 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    chk("play_drain", exp_q.size(), 0);
    exp_q.delete();
`ifdef LOOP_PLAY_EN
    do_stop();
`endif
    chk("play_end_state", state, 0);
    chk("play_end_note", note_out, 15);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", state, 0);
    chk("rst_note", note_out, 15);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    rst = 1'b0;
    tick();

    // Record 3, 5, 7 and play back
    do_rec();
    chk("rec_state", state, 1);
    chk("rec_count0", count, 0);
    do_note(4'd3);
    do_note(4'd5);
    do_note(4'd7);
    chk("rec_count3", count, 3);
    chk("rec_note_rest", note_out, 15);
    run_play(3, 4'd3, 4'd5, 4'd7, 4'd0);
    chk("play_count_kept", count, 3);

    // rec_start beats play_start on the same cycle
    rec_start  = 1'b1;
    play_start = 1'b1;
    tick();
    rec_start  = 1'b0;
    play_start = 1'b0;
    chk("prio_rec_state", state, 1);
    chk("prio_rec_count", count, 0);

    // Overflow: fifth note dropped
    do_note(4'd9);
    do_note(4'd10);
    do_note(4'd11);
    chk("fill_full_n3", full, 0);
    do_note(4'd12);
    chk("fill_full", full, 1);
    chk("fill_count4", count, 4);
    do_note(4'd13);
    chk("ovf_count", count, 4);
    chk("ovf_empty", empty, 0);
    run_play(4, 4'd9, 4'd10, 4'd11, 4'd12);

    // Invalid note values dropped
    do_rec();
    do_note(4'd2);
    do_note(4'd14);
    chk("bad14_count", count, 1);
    do_note(4'd15);
    chk("bad15_count", count, 1);

    // play_start with an empty buffer stays idle
    do_rec();
    chk("clr_empty", empty, 1);
    do_stop();
    do_play();
    chk("empty_play_state", state, 0);
    chk("empty_play_note", note_out, 15);
    tick();
    chk("empty_play_state2", state, 0);

    // stop wins over play_start during RECORD, count preserved
    do_rec();
    do_note(4'd4);
    do_note(4'd6);
    stop       = 1'b1;
    play_start = 1'b1;
    tick();
    stop       = 1'b0;
    play_start = 1'b0;
    chk("stop_prio_state", state, 0);
    chk("stop_prio_count", count, 2);
    do_play();
    chk("play_entry_note", note_out, 4);
    chk("play_entry_state", state, 2);
    tick();
    chk("play_hold_note", note_out, 4);

    // Asynchronous reset mid-play
    #2 rst = 1'b1;
    #1;
    chk("arst_note", note_out, 15);
    chk("arst_state", state, 0);
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    rst = 1'b0;
    tick();

    // Two-note playback (loops when LOOP_PLAY_EN is defined)
    do_rec();
    do_note(4'd1);
    do_note(4'd2);
    run_play(2, 4'd1, 4'd2, 4'd0, 4'd0);
    chk("final_count", count, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_note_recorder.md
KEY_NOTE_RECORDER -- requirements
Module: key_note_recorder

Interface
REQ-001 Parameter DEPTH, 16, number of note entries stored; power of two.
REQ-002 Parameter BEAT_CYCLES, 25_000_000, clk cycles each note is held during playback (0.25 s at 100 MHz).
REQ-003 Port clk  input  1  system clock; the block uses this single clock and no other.
REQ-004 Port rst  input  1  reset; asynchronous, active-high.
REQ-005 Port note_in  input  4  note number from the ASCII-to-note stage; 0..13 are valid notes.
REQ-006 Port note_valid  input  1  one-cycle pulse; note_in is valid on this cycle (keyboard one-pulse).
REQ-007 Port rec_start  input  1  one-cycle pulse; clear the buffer and begin recording.
REQ-008 Port play_start  input  1  one-cycle pulse; begin playback.
REQ-009 Port stop  input  1  one-cycle pulse; return to idle.
REQ-010 Port note_out  output  4  note number to the note-division stage; 4'd15 means rest/silence.
REQ-011 Port state  output  2  current state: 0 IDLE, 1 RECORD, 2 PLAY.
REQ-012 Port count  output  $clog2(DEPTH)+1  number of stored notes.
REQ-013 Port full  output  1  high when count == DEPTH.
REQ-014 Port empty  output  1  high when count == 0.

Function
REQ-015 The FSM SHALL have three states (IDLE, RECORD, PLAY); on simultaneous pulses, priority is stop > rec_start > play_start.
REQ-016 In IDLE, rec_start SHALL enter RECORD and clear the stored contents (count = 0) on the next cycle.
REQ-017 In IDLE, play_start SHALL enter PLAY only if count > 0; with count == 0, the FSM SHALL stay in IDLE.
REQ-018 In RECORD, a note_valid with note_in ≤ 13 and count < DEPTH SHALL write note_in at the write pointer and increment count by 1, effective the next cycle.
REQ-019 In RECORD, a note_valid with note_in > 13, or a note_valid while full, SHALL be dropped with no state change.
REQ-020 In RECORD, rec_start SHALL restart recording (count = 0), and play_start SHALL enter PLAY if count > 0.
REQ-021 On PLAY entry, the read pointer and beat counter SHALL reset to 0, and note_out SHALL equal entry 0 on the cycle after the accepted play_start.
REQ-022 In PLAY, each entry SHALL drive note_out for exactly BEAT_CYCLES cycles, after which the next entry is driven.
REQ-023 After the last entry's beat, the block SHALL return to IDLE (without LOOP_PLAY_EN) or wrap the read pointer to 0 (with it).
REQ-024 In PLAY, note_valid SHALL be ignored.
REQ-025 stop in any state SHALL enter IDLE next cycle; stored notes and count SHALL be preserved.
REQ-026 note_out SHALL be 4'd15 in IDLE and RECORD.
REQ-027 note_out, state, count, full and empty SHALL all be registered outputs.

Reset
REQ-028 Asserting rst SHALL immediately force: state IDLE, note_out 4'd15, count 0, read/write pointers 0, beat counter 0, full 0, empty 1.
REQ-029 Reset during PLAY or RECORD SHALL abandon the operation; storage contents need not be cleared.

Configuration
REQ-030 Macro LOOP_PLAY_EN: if defined, playback SHALL loop indefinitely until stop or rec_start; if undefined, playback SHALL stop after one pass, returning to IDLE with note_out 4'd15.

Structure
REQ-031 A shared package SHALL hold: the state enum encoding, the REST note constant 4'd15, and MAX_NOTE = 13.
REQ-032 Storage and pointers SHALL live in one sub-module, note_fifo (write port, indexed read, count); the FSM and beat counter SHALL stay in key_note_recorder.

Verification (bench uses BEAT_CYCLES = 4, DEPTH = 4)
REQ-033 Reset, then rec_start; notes 3, 5, 7; play_start -> note_out is 3, 5, 7 for 4 cycles each, then 15; state returns to 0.
REQ-034 Record 5 valid notes -> count saturates at 4 and full = 1; the 5th note is absent from playback.
REQ-035 note_in = 14 with note_valid during RECORD -> count unchanged.
REQ-036 play_start with empty = 1 -> state stays 0 and note_out stays 15.
REQ-037 stop and play_start on the same cycle during RECORD -> IDLE, count preserved; rst mid-PLAY -> note_out 15 immediately.
REQ-038 With LOOP_PLAY_EN, record 2 notes (1, 2) and play -> sequence 1, 2, 1, 2 repeats until stop.
